// File: rtl/ustc_fan_pkg.sv
// Shared definitions for the FAN packer and reduction network: lane control
// bit positions, default widths, FSM state type and lane placement helper.
package ustc_fan_pkg;

  localparam int DW_DATA_DEF = 8;
  localparam int DW_ROW_DEF  = 4;
  localparam int DW_CTRL_DEF = 4;
  localparam int NUM_IN_DEF  = 32;

  localparam int CTRL_VALID = 3;
  localparam int CTRL_CONT  = 2;
  localparam int CTRL_START = 1;
  localparam int CTRL_END   = 0;

  typedef enum logic {
    S_FILL = 1'b0,
    S_HOLD = 1'b1
  } pack_state_e;

  // Lane 0 sits at the top of the packed line; returns the LSB of lane `lane`.
  function automatic int lane_lsb(input int lane, input int num_in, input int dw_line);
    return (num_in - 1 - lane) * dw_line;
  endfunction

endpackage

// File: rtl/ustc_fan_line_reg.sv
// Output holding register between the packer and the FAN network.
// free_o tells the packer the slot can take a new line on this edge.
module ustc_fan_line_reg
  import ustc_fan_pkg::*;
#(
  parameter int W = NUM_IN_DEF * (DW_DATA_DEF + DW_ROW_DEF + DW_CTRL_DEF)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] line_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] line_o,
  output logic         free_o
);

  logic         valid_q;
  logic [W-1:0] line_q;

  assign free_o  = !valid_q || ready_i;
  assign valid_o = valid_q;
  assign line_o  = line_q;

  // A load wins over a consume so back-to-back lines keep valid high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      line_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      line_q  <= line_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/ustc_fan_pack.sv
// Packs a row-sorted (row, product) stream into NUM_IN-lane lines with
// group-delimiting control flags; the build line is double-buffered with the output.
module ustc_fan_pack
  import ustc_fan_pkg::*;
#(
  parameter int DW_DATA = DW_DATA_DEF,
  parameter int DW_ROW  = DW_ROW_DEF,
  parameter int DW_CTRL = DW_CTRL_DEF,
  parameter int DW_LINE = DW_DATA + DW_ROW + DW_CTRL,
  parameter int NUM_IN  = NUM_IN_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DW_DATA-1:0]        in_data,
  input  logic [DW_ROW-1:0]         in_row,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_IN*DW_LINE-1:0] out
);

  localparam int PTR_W   = $clog2(NUM_IN);
  localparam int END_BIT = DW_DATA + DW_ROW + CTRL_END;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_IN - 1);

  pack_state_e                state_q;
  logic [PTR_W-1:0]           ptr_q;
  logic [DW_LINE-1:0]         build_q [NUM_IN];
  logic [DW_LINE-1:0]         build_d [NUM_IN];
  logic [DW_ROW-1:0]          prev_row_q;
  logic                       open_q;
  logic                       cont_pend_q;
  logic                       accept, last_lane, row_chg, close_line, slot_free, load;
  logic [DW_CTRL-1:0]         ctrl;
  logic [NUM_IN*DW_LINE-1:0]  line_flat;

  assign in_ready   = (state_q == S_FILL);
  assign accept     = in_valid && in_ready;
  assign last_lane  = (ptr_q == PTR_LAST);
  assign row_chg    = (in_row != prev_row_q);
  assign close_line = accept && (in_last || last_lane);
  assign load       = slot_free && (close_line || state_q == S_HOLD);

  always_comb begin
    ctrl             = '0;
    ctrl[CTRL_VALID] = 1'b1;
    ctrl[CTRL_START] = (ptr_q == '0) || row_chg;
    ctrl[CTRL_CONT]  = (ptr_q == '0) && cont_pend_q && open_q && !row_chg;
    ctrl[CTRL_END]   = in_last || last_lane;
  end

  // A row change also terminates the group sitting in the previous lane.
  always_comb begin
    build_d = build_q;
    if (accept) begin
      build_d[ptr_q] = {ctrl, in_row, in_data};
      if (row_chg && ptr_q != '0) begin
        build_d[ptr_q - PTR_W'(1)][END_BIT] = 1'b1;
      end
    end
  end

  always_comb begin
    line_flat = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      line_flat[lane_lsb(k, NUM_IN, DW_LINE) +: DW_LINE] = build_d[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_FILL;
      ptr_q       <= '0;
      prev_row_q  <= '0;
      open_q      <= 1'b0;
      cont_pend_q <= 1'b0;
      for (int k = 0; k < NUM_IN; k++) build_q[k] <= '0;
    end else begin
      if (accept) begin
        prev_row_q <= in_last ? '0 : in_row;
        open_q     <= !in_last;
        ptr_q      <= close_line ? '0 : ptr_q + PTR_W'(1);
        if (close_line) cont_pend_q <= !in_last;
      end
      if (load) begin
        state_q <= S_FILL;
        for (int k = 0; k < NUM_IN; k++) build_q[k] <= '0;
      end else begin
        for (int k = 0; k < NUM_IN; k++) build_q[k] <= build_d[k];
        if (close_line) state_q <= S_HOLD;
      end
    end
  end

  ustc_fan_line_reg #(
    .W(NUM_IN * DW_LINE)
  ) u_line_reg (
    .clk    (clk),
    .rst    (rst),
    .load_i (load),
    .line_i (line_flat),
    .ready_i(out_ready),
    .valid_o(out_valid),
    .line_o (out),
    .free_o (slot_free)
  );

endmodule
